// File: rtl/cam_tx_pkg.sv
// Shared types and constants for the camera transmitter: FSM states, pattern
// modes, colour-bar table and LFSR parameters.
package cam_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBP,
        ACTIVE,
        HGAP
    } state_t;

    localparam logic [1:0] MODE_CNT   = 2'd0;
    localparam logic [1:0] MODE_BARS  = 2'd1;
    localparam logic [1:0] MODE_SOLID = 2'd2;
    localparam logic [1:0] MODE_LFSR  = 2'd3;

    // Index 0 is the left-most bar.
    localparam logic [0:7][11:0] BAR_TABLE = {
        12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
        12'hF0F, 12'hF00, 12'h00F, 12'h000
    };

    localparam logic [11:0] LFSR_SEED = 12'hACE;
    // Taps 12,11,10,4 expressed as a mask over bits [11:0].
    localparam logic [11:0] LFSR_TAPS = 12'b1110_0000_1000;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [11:0] lfsr_next(input logic [11:0] s);
        return {s[10:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/cam_tx_gen_if.sv
// Camera-side bus of the transmitter: control inputs and the
// vsync/href/data stream with status flags.
interface cam_tx_gen_if;
    logic        i_start;
    logic [1:0]  i_mode;
    logic [11:0] i_color;
    logic        o_vsync;
    logic        o_href;
    logic [7:0]  o_data;
    logic        o_busy;
    logic        o_frame_done;

    modport master (
        input  i_start, i_mode, i_color,
        output o_vsync, o_href, o_data, o_busy, o_frame_done
    );

    modport slave (
        output i_start, i_mode, i_color,
        input  o_vsync, o_href, o_data, o_busy, o_frame_done
    );
endinterface

// File: rtl/cam_tx_pattern.sv
// Combinational pixel selection for the transmitter. The LFSR input port only
// exists when CAM_TX_GEN_LFSR_EN is defined; otherwise mode 3 falls back to the counter.
module cam_tx_pattern
    import cam_tx_pkg::*;
#(
    parameter int H_PIXELS = 10,
    parameter int RW       = 4,
    parameter int CW       = 4
) (
    input  logic [1:0]    mode,
    input  logic [RW-1:0] row,
    input  logic [CW-1:0] col,
`ifdef CAM_TX_GEN_LFSR_EN
    input  logic [11:0]   lfsr,
`endif
    input  logic [11:0]   color,
    output logic [11:0]   pix
);

    always_comb begin
        pix = 12'(32'(row) * H_PIXELS + 32'(col));
        case (mode)
            MODE_BARS:  pix = BAR_TABLE[3'((32'(col) * 8) / H_PIXELS)];
            MODE_SOLID: pix = color;
`ifdef CAM_TX_GEN_LFSR_EN
            MODE_LFSR:  pix = lfsr;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/cam_tx_gen.sv
// Camera-side frame generator: vsync, back porch, then rows of RGB444 pixels
// sent as two bytes each. Optional LFSR pattern under CAM_TX_GEN_LFSR_EN.
module cam_tx_gen
    import cam_tx_pkg::*;
#(
    parameter int         H_PIXELS     = 10,
    parameter int         V_ROWS       = 10,
    parameter int         VSYNC_CYCLES = 3,
    parameter int         VBP_CYCLES   = 17,
    parameter int         HGAP_CYCLES  = 5,
    parameter logic [3:0] PAD_NIBBLE   = 4'hF
) (
    input logic          i_clk,
    input logic          i_rst,
    cam_tx_gen_if.master cam
);

    localparam int TMAX = (VSYNC_CYCLES > VBP_CYCLES)
                        ? ((VSYNC_CYCLES > HGAP_CYCLES) ? VSYNC_CYCLES : HGAP_CYCLES)
                        : ((VBP_CYCLES > HGAP_CYCLES) ? VBP_CYCLES : HGAP_CYCLES);
    localparam int TW = cnt_w(TMAX);
    localparam int BW = cnt_w(2 * H_PIXELS);
    localparam int CW = cnt_w(H_PIXELS);
    localparam int RW = cnt_w(V_ROWS);

    localparam logic [TW-1:0] VS_LAST   = TW'(VSYNC_CYCLES - 1);
    localparam logic [TW-1:0] VBP_LAST  = TW'(VBP_CYCLES - 1);
    localparam logic [TW-1:0] HG_LAST   = TW'(HGAP_CYCLES - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(2 * H_PIXELS - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(V_ROWS - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [BW-1:0] byte_q, byte_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [1:0]    mode_q, mode_d;
    logic [11:0]   color_q, color_d;
`ifdef CAM_TX_GEN_LFSR_EN
    logic [11:0]   lfsr_q, lfsr_d;
`endif

    logic          vsync_q, vsync_d;
    logic          href_q, href_d;
    logic [7:0]    data_q, data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          latch;
    logic [11:0]   pix;

    cam_tx_pattern #(
        .H_PIXELS (H_PIXELS),
        .RW       (RW),
        .CW       (CW)
    ) u_pattern (
        .mode  (mode_q),
        .row   (row_q),
        .col   (col_q),
`ifdef CAM_TX_GEN_LFSR_EN
        .lfsr  (lfsr_q),
`endif
        .color (color_q),
        .pix   (pix)
    );

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        byte_d  = byte_q;
        col_d   = col_q;
        row_d   = row_q;
        mode_d  = mode_q;
        color_d = color_q;
`ifdef CAM_TX_GEN_LFSR_EN
        lfsr_d  = lfsr_q;
`endif
        latch   = 1'b0;

        // Outputs are a registered image of the current state, so every
        // output trails the state register by exactly one cycle.
        vsync_d = (state_q == VSYNC);
        href_d  = (state_q == ACTIVE);
        busy_d  = (state_q != IDLE);
        done_d  = 1'b0;
        data_d  = 8'h00;
        if (state_q == ACTIVE)
            data_d = byte_q[0] ? pix[7:0] : {PAD_NIBBLE, pix[11:8]};

        case (state_q)
            IDLE: begin
                if (cam.i_start) begin
                    state_d = VSYNC;
                    latch   = 1'b1;
                end
            end
            VSYNC: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == VS_LAST) begin
                    tmr_d   = '0;
                    state_d = VBP;
                end
            end
            VBP: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == VBP_LAST) begin
                    tmr_d   = '0;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                byte_d = byte_q + 1'b1;
                if (byte_q[0]) begin
                    col_d = col_q + 1'b1;
`ifdef CAM_TX_GEN_LFSR_EN
                    lfsr_d = lfsr_next(lfsr_q);
`endif
                end
                if (byte_q == BYTE_LAST) begin
                    byte_d  = '0;
                    col_d   = '0;
                    state_d = HGAP;
                end
            end
            HGAP: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == HG_LAST) begin
                    tmr_d = '0;
                    if (row_q == ROW_LAST) begin
                        done_d = 1'b1;
                        row_d  = '0;
                        if (cam.i_start) begin
                            state_d = VSYNC;
                            latch   = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = ACTIVE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (latch) begin
            mode_d  = cam.i_mode;
            color_d = cam.i_color;
            tmr_d   = '0;
            byte_d  = '0;
            col_d   = '0;
            row_d   = '0;
`ifdef CAM_TX_GEN_LFSR_EN
            lfsr_d  = LFSR_SEED;
`endif
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            byte_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            mode_q  <= '0;
            color_q <= '0;
`ifdef CAM_TX_GEN_LFSR_EN
            lfsr_q  <= LFSR_SEED;
`endif
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            byte_q  <= byte_d;
            col_q   <= col_d;
            row_q   <= row_d;
            mode_q  <= mode_d;
            color_q <= color_d;
`ifdef CAM_TX_GEN_LFSR_EN
            lfsr_q  <= lfsr_d;
`endif
            vsync_q <= vsync_d;
            href_q  <= href_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign cam.o_vsync      = vsync_q;
    assign cam.o_href       = href_q;
    assign cam.o_data       = data_q;
    assign cam.o_busy       = busy_q;
    assign cam.o_frame_done = done_q;

endmodule

// File: tb/tb_cam_tx_gen.sv
// Bench for cam_tx_gen: default-geometry instance checked against a byte
// scoreboard, plus an H_PIXELS=8 instance for the colour-bar row.
module tb_cam_tx_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cam_tx_gen_if ca ();
    cam_tx_gen_if cb ();

    cam_tx_gen u_a (.i_clk(clk), .i_rst(rst), .cam(ca));
    cam_tx_gen #(.H_PIXELS(8)) u_b (.i_clk(clk), .i_rst(rst), .cam(cb));

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] sb[$];

    logic [11:0] bars_t [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                12'hF0F, 12'hF00, 12'h00F, 12'h000};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Scoreboard consumer: every href byte of DUT A must match the queue head.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (ca.o_href === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_extra: got %0h want no byte", ca.o_data);
                end else begin
                    chk("byte", ca.o_data, sb.pop_front());
                end
            end else begin
                chk("idle_data", ca.o_data, 0);
            end
        end
    end

    task automatic push_frame(input logic [1:0] m, input logic [11:0] c);
        logic [11:0] lf;
        logic [11:0] p;
        lf = 12'hACE;
        for (int r = 0; r < 10; r++) begin
            for (int x = 0; x < 10; x++) begin
                case (m)
                    2'd1: p = bars_t[(x * 8) / 10];
                    2'd2: p = c;
`ifdef CAM_TX_GEN_LFSR_EN
                    2'd3: p = lf;
`endif
                    default: p = 12'(r * 10 + x);
                endcase
                sb.push_back({4'hF, p[11:8]});
                sb.push_back(p[7:0]);
                lf = {lf[10:0], lf[11] ^ lf[10] ^ lf[9] ^ lf[3]};
            end
        end
    endtask

    task automatic run_frame(input logic [1:0] m, input logic [11:0] c,
                             input bit chg, input logic [15:0] px0);
        int n, hb, rows, k;
        logic pv, vs;
        @(negedge clk);
        ca.i_mode  = m;
        ca.i_color = c;
        ca.i_start = 1'b1;
        push_frame(m, c);
        @(negedge clk);
        ca.i_start = 1'b0;
        chk("vsync_lag", ca.o_vsync, 0);
        @(negedge clk);
        chk("vsync_rise", ca.o_vsync, 1);
        n = 0;
        while (ca.o_vsync && n < 20) begin n++; @(negedge clk); end
        chk("vsync_width", n, 3);
        n = 0;
        while (!ca.o_href && n < 50) begin n++; @(negedge clk); end
        chk("vbp_gap", n, 17);
        chk("px0_hi", ca.o_data, px0[15:8]);
        @(negedge clk);
        chk("px0_lo", ca.o_data, px0[7:0]);
        hb = 2; rows = 1; pv = 1'b1; k = 0;
        while (k < 400) begin
            @(negedge clk);
            k++;
            if (chg && k == 60) begin
                ca.i_color = ~c;
                ca.i_mode  = m ^ 2'd1;
            end
            if (ca.o_href) hb++;
            if (ca.o_href && !pv) rows++;
            pv = ca.o_href;
            if (ca.o_frame_done) break;
        end
        chk("frame_done", ca.o_frame_done, 1);
        chk("busy_at_done", ca.o_busy, 1);
        chk("href_bytes", hb, 200);
        chk("rows", rows, 10);
        @(negedge clk);
        chk("done_pulse", ca.o_frame_done, 0);
        chk("busy_fall", ca.o_busy, 0);
        vs = 1'b0;
        repeat (5) begin @(negedge clk); if (ca.o_vsync) vs = 1'b1; end
        chk("one_frame", vs, 0);
        chk("sb_drained", sb.size(), 0);
    endtask

    typedef struct {
        logic [1:0]  m;
        logic [11:0] c;
        bit          chg;
        logic [15:0] px0;
    } vec_t;

    vec_t vt[5];

    initial begin
        int c, nd, nr, k;
        int rises[3];
        logic pv, chk_next;
        logic [7:0] hi, lo;

        vt[0] = '{2'd0, 12'h000, 1'b0, 16'hF000};
        vt[1] = '{2'd2, 12'h3A5, 1'b1, 16'hF3A5};
        vt[2] = '{2'd2, 12'h5C3, 1'b0, 16'hF5C3};
        vt[3] = '{2'd1, 12'h000, 1'b0, 16'hFFFF};
`ifdef CAM_TX_GEN_LFSR_EN
        vt[4] = '{2'd3, 12'h123, 1'b0, 16'hFACE};
`else
        vt[4] = '{2'd3, 12'h123, 1'b0, 16'hF000};
`endif

        rst = 1'b1;
        ca.i_start = 1'b0; ca.i_mode = 2'd0; ca.i_color = 12'h000;
        cb.i_start = 1'b0; cb.i_mode = 2'd0; cb.i_color = 12'h000;
        repeat (3) @(negedge clk);
        chk("rst_vsync", ca.o_vsync, 0);
        chk("rst_href", ca.o_href, 0);
        chk("rst_data", ca.o_data, 0);
        chk("rst_busy", ca.o_busy, 0);
        chk("rst_done", ca.o_frame_done, 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++)
            run_frame(vt[i].m, vt[i].c, vt[i].chg, vt[i].px0);

        // Colour bars on the 8-pixel instance: one row decodes to the table.
        @(negedge clk);
        cb.i_mode = 2'd1; cb.i_start = 1'b1;
        @(negedge clk);
        cb.i_start = 1'b0;
        k = 0;
        while (!cb.o_href && k < 60) begin k++; @(negedge clk); end
        chk("bars_href", cb.o_href, 1);
        for (int p = 0; p < 8; p++) begin
            hi = cb.o_data;
            @(negedge clk);
            lo = cb.o_data;
            @(negedge clk);
            chk("bars_pad", hi[7:4], 4'hF);
            chk("bars_pix", {hi[3:0], lo}, bars_t[p]);
        end
        k = 0;
        while (!cb.o_frame_done && k < 300) begin k++; @(negedge clk); end
        chk("bars_done", cb.o_frame_done, 1);

        // Back-to-back frames with i_start held high.
        for (int f = 0; f < 3; f++) push_frame(2'd0, 12'h000);
        @(negedge clk);
        ca.i_mode = 2'd0; ca.i_start = 1'b1;
        c = 0; nd = 0; nr = 0; pv = 1'b0; chk_next = 1'b0;
        while (c < 1000) begin
            @(negedge clk);
            c++;
            if (ca.o_vsync && !pv && nr < 3) begin rises[nr] = c; nr++; end
            if (chk_next) begin chk("vs_after_done", ca.o_vsync, 1); chk_next = 1'b0; end
            pv = ca.o_vsync;
            if (ca.o_frame_done) begin
                nd++;
                if (nd < 3) chk_next = 1'b1;
                if (nd == 2) ca.i_start = 1'b0;
                if (nd == 3) break;
            end
        end
        chk("b2b_frames", nd, 3);
        chk("b2b_rises", nr, 3);
        chk("period_1", rises[1] - rises[0], 270);
        chk("period_2", rises[2] - rises[1], 270);
        @(negedge clk);
        chk("b2b_idle", ca.o_busy, 0);
        chk("b2b_drained", sb.size(), 0);

        // Reset during row 4, then a clean restart from pixel 0.
        push_frame(2'd0, 12'h000);
        @(negedge clk);
        ca.i_start = 1'b1;
        @(negedge clk);
        ca.i_start = 1'b0;
        nr = 0; pv = 1'b0; k = 0;
        while (nr < 5 && k < 400) begin
            @(negedge clk);
            k++;
            if (ca.o_href && !pv) nr++;
            pv = ca.o_href;
        end
        chk("row4_reached", nr, 5);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_vsync", ca.o_vsync, 0);
        chk("arst_href", ca.o_href, 0);
        chk("arst_data", ca.o_data, 0);
        chk("arst_busy", ca.o_busy, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        run_frame(2'd0, 12'h000, 1'b0, 16'hF000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cam_tx_gen.md
# cam_tx_gen

Synthesizable camera-side transmitter for the pixel-capture path. It generates complete frames on the camera interface (vsync, href, 8-bit data, two bytes per RGB444 pixel) in the byte format the capture block consumes. It sits in the camera-clock domain as an on-chip stand-in for the sensor, for bring-up and loopback through the 24→125→25 MHz FIFO chain. Frame geometry, porches and the test pattern are programmable.

## Interface
- H_PIXELS, 10, pixels per row (row = 2*H_PIXELS bytes)
- V_ROWS, 10, rows per frame
- VSYNC_CYCLES, 3, vsync high width
- VBP_CYCLES, 17, vsync-low cycles before first row
- HGAP_CYCLES, 5, href-low cycles after every row, including the last
- PAD_NIBBLE, 4'hF, upper nibble of the first byte of each pixel
- i_clk  in  1  camera pixel clock; all logic on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  level; while high, frames run back to back
- i_mode  in  2  pattern: 0 counter, 1 colour bars, 2 solid, 3 LFSR
- i_color  in  12  solid colour {R,G,B}
- o_vsync  out  1  frame sync, active high
- o_href  out  1  row valid
- o_data  out  8  pixel byte
- o_busy  out  1  high in every state except IDLE
- o_frame_done  out  1  single-cycle pulse at end of frame

## Operation
- FSM states: IDLE, VSYNC, VBP, ACTIVE, HGAP.
- IDLE: if i_start=1, go to VSYNC. Latch i_mode and i_color. Clear the row, byte and pixel counters.
- VSYNC: o_vsync=1 for VSYNC_CYCLES cycles, then go to VBP.
- VBP: VBP_CYCLES cycles, then go to ACTIVE.
- ACTIVE: o_href=1 for 2*H_PIXELS cycles.
  - Even byte = {PAD_NIBBLE, pix[11:8]}.
  - Odd byte = pix[7:0].
  - Pixel advances after each odd byte.
  - Then go to HGAP.
- HGAP: HGAP_CYCLES cycles.
  - If more rows remain, go to ACTIVE.
  - Otherwise assert o_frame_done in the last HGAP cycle. Then go to VSYNC if i_start=1 (relatch mode and colour), else IDLE.
- Patterns (pix is 12 bits):
  - Counter: row*H_PIXELS+col, mod 4096, restarting at 0 each frame.
  - Bars: colour table entry at index (col*8)/H_PIXELS, 3-bit, integer division.
  - Solid: latched i_color.
  - LFSR: see Configuration.
- Deasserting i_start mid-frame does not abort; the frame completes, then the FSM goes to IDLE.
- i_mode and i_color changes mid-frame are ignored until the next frame latch.
- Outside ACTIVE: o_href=0 and o_data=8'h00.
- Counters are sized with $clog2 of their maximum, minimum 1 bit.

## Timing
- Outputs registered. Reset values: o_vsync=0, o_href=0, o_data=0, o_busy=0, o_frame_done=0, FSM=IDLE.
- i_start sampled high at edge N in IDLE → o_vsync=1 from edge N+1.
- o_href and o_data change together on the same edge; the first byte is valid with the first href-high cycle.
- Frame length = VSYNC_CYCLES + VBP_CYCLES + V_ROWS*(2*H_PIXELS+HGAP_CYCLES) cycles.
- With i_start held high, the next o_vsync rises on the edge after o_frame_done.
- i_rst asserted mid-frame: all outputs go to reset values immediately (asynchronous) and the FSM goes to IDLE. After release, the next frame starts from row 0.

## Configuration
- CAM_TX_GEN_LFSR_EN defined: mode 3 outputs a 12-bit Fibonacci LFSR.
  - Taps 12,11,10,4.
  - Seed 12'hACE, loaded at each frame latch.
  - Steps once per pixel.
- Not defined: no LFSR logic is built, and mode 3 behaves as mode 0 (counter).

## Structure
- Package cam_tx_pkg:
  - state_t enum (IDLE, VSYNC, VBP, ACTIVE, HGAP)
  - mode constants
  - 8-entry 12-bit colour-bar table: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000
  - LFSR seed and tap constants
- One sub-module, cam_tx_pattern: combinational pixel selection from mode, row, col and LFSR state. The LFSR register stays in the top level.

## Test plan
- Defaults, i_mode=0, i_start pulsed for 1 cycle → exactly one frame; vsync high 3 cycles; first href 17 cycles after vsync falls; 10 rows of 20 bytes; pixel 0 bytes = 8'hF0, 8'h00; pixel 11 bytes = 8'hF0, 8'h0B; one o_frame_done pulse; o_busy falls on the edge after the pulse.
- H_PIXELS=8, i_mode=1 → a row decodes to pixels FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
- i_mode=2, i_color=12'h3A5 → every pixel is 8'hF3, 8'hA5; change i_color mid-frame → no effect until the next frame.
- i_start held high for 3 frames → frame period 3+17+10*25=270 cycles; vsync rises on the edge after each o_frame_done.
- Assert i_rst during row 4 → outputs 0 immediately; after release with i_start=1, the frame restarts at pixel 0.
- i_mode=3: with CAM_TX_GEN_LFSR_EN, pixel 0 = 12'hACE and later pixels match the reference LFSR model; without it, the stream matches the counter pattern.
